// File: rtl/step_pkg.sv
// Shared types and defaults for the stepper-motor STEP/DIR pulse generator.
package step_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD
    } step_state_t;

    localparam int PULSE_HIGH_DEF = 4;
    localparam int DIR_SETUP_DEF  = 8;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that parks at zero; times the SETUP, HIGH and LOW phases.
module step_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR/ENABLE generator: whole pulses of max(period, 2*PULSE_HIGH) cycles,
// DIR setup before the first edge after a direction change, optional pulse count.
//
// state | meaning
// IDLE  | waiting for a start request
// SETUP | dir_out just changed, step held low for DIR_SETUP cycles
// HIGH  | step high for PULSE_HIGH cycles
// LOW   | step low for the remainder of the effective period
// HOLD  | counted run finished, waiting for drv_en to drop
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PULSE_HIGH = PULSE_HIGH_DEF,
    parameter int DIR_SETUP  = DIR_SETUP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drv_en,
    input  logic             dir,
    input  logic             counter_en,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] pulse_number,
    output logic             step,
    output logic             dir_out,
    output logic             drv_en_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pulse_cnt
);

    localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2 * PULSE_HIGH);
    localparam logic [WIDTH-1:0] HIGH_LEN   = WIDTH'(PULSE_HIGH);
    localparam logic [WIDTH-1:0] HIGH_LOAD  = WIDTH'(PULSE_HIGH - 1);
    localparam logic [WIDTH-1:0] SETUP_LOAD = WIDTH'(DIR_SETUP - 1);

    step_state_t      state;
    logic             cnt_mode;
    logic [WIDTH-1:0] pulse_target;
    logic [WIDTH-1:0] peff;
    logic [WIDTH-1:0] peff_in;
    logic [WIDTH-1:0] cnt_next;
    logic             dir_change;
    logic             start_ok;
    logic             timer_load;
    logic [WIDTH-1:0] timer_val;
    logic             timer_zero;

    assign peff_in    = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    assign cnt_next   = pulse_cnt + WIDTH'(1);
    assign dir_change = (dir != dir_out);
    assign start_ok   = drv_en && (period != '0) && (!counter_en || (pulse_number != '0));

    // The timer is reloaded whenever the current phase ends, with the length of
    // the phase the FSM is about to enter; in IDLE it is preloaded every cycle.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = dir_change ? SETUP_LOAD : HIGH_LOAD;
        case (state)
            IDLE, HOLD: begin
                timer_load = 1'b1;
            end
            SETUP: begin
                timer_load = timer_zero;
                timer_val  = HIGH_LOAD;
            end
            HIGH: begin
                timer_load = timer_zero;
                timer_val  = peff - HIGH_LEN - WIDTH'(1);
            end
            LOW: begin
                timer_load = timer_zero;
            end
            default: begin
                timer_load = 1'b1;
            end
        endcase
    end

    step_timer #(
        .WIDTH(WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            step         <= 1'b0;
            dir_out      <= 1'b0;
            drv_en_out   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pulse_cnt    <= '0;
            cnt_mode     <= 1'b0;
            pulse_target <= '0;
            peff         <= '0;
        end else begin
            drv_en_out <= drv_en;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cnt_mode     <= counter_en;
                        pulse_target <= pulse_number;
                        peff         <= peff_in;
                        pulse_cnt    <= '0;
                        busy         <= 1'b1;
                        if (dir_change) begin
                            dir_out <= dir;
                            state   <= SETUP;
                        end else begin
                            step  <= 1'b1;
                            state <= HIGH;
                        end
                    end
                end
                SETUP: begin
                    if (timer_zero) begin
                        step  <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (timer_zero) begin
                        step  <= 1'b0;
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (timer_zero) begin
                        pulse_cnt <= cnt_next;
                        if (cnt_mode && (cnt_next == pulse_target)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= HOLD;
                        end else if (!drv_en || (period == '0)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            peff <= peff_in;
                            if (dir_change) begin
                                dir_out <= dir;
                                state   <= SETUP;
                            end else begin
                                step  <= 1'b1;
                                state <= HIGH;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!drv_en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    step  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: edge timing, direction setup, stop, clamp, count and reset.
module tb_step_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        drv_en;
    logic        dir;
    logic        counter_en;
    logic [15:0] period;
    logic [15:0] pulse_number;
    logic        step;
    logic        dir_out;
    logic        drv_en_out;
    logic        busy;
    logic        done;
    logic [15:0] pulse_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s        = 0;

    int rise_q[$];
    int hi_q[$];
    int hi_run    = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int done_pcnt = -1;
    int flip_cyc  = -1;
    logic step_q  = 1'b0;
    logic dir_q   = 1'b0;

    step_pulse_gen u_dut (
        .clk          (clk),
        .rst          (rst),
        .drv_en       (drv_en),
        .dir          (dir),
        .counter_en   (counter_en),
        .period       (period),
        .pulse_number (pulse_number),
        .step         (step),
        .dir_out      (dir_out),
        .drv_en_out   (drv_en_out),
        .busy         (busy),
        .done         (done),
        .pulse_cnt    (pulse_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step === 1'b1 && step_q === 1'b0) rise_q.push_back(cyc);
        if (step === 1'b1) begin
            hi_run++;
        end else if (step_q === 1'b1) begin
            hi_q.push_back(hi_run);
            hi_run = 0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc;
            done_pcnt = int'(pulse_cnt);
        end
        if (dir_out !== dir_q) flip_cyc = cyc;
        step_q = step;
        dir_q  = dir_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rise_q.delete();
        hi_q.delete();
        hi_run    = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        done_pcnt = -1;
        flip_cyc  = -1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_run(input logic ce, input logic d, input logic [15:0] per,
                             input logic [15:0] pn);
        @(negedge clk);
        clear_mon();
        counter_en   = ce;
        dir          = d;
        period       = per;
        pulse_number = pn;
        drv_en       = 1'b1;
        s            = cyc;
    endtask

    task automatic stop_and_idle();
        @(negedge clk);
        drv_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy == 1'b0) break;
            @(negedge clk);
        end
        chk("idle_after_stop", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rise_at(input string tag, input int idx, input int exp);
        chk(tag, (rise_q.size() > idx) ? rise_q[idx] : -1, exp);
    endtask

    initial begin
        rst          = 1'b1;
        drv_en       = 1'b0;
        dir          = 1'b0;
        counter_en   = 1'b0;
        period       = '0;
        pulse_number = '0;
        repeat (3) @(negedge clk);
        chk("rst_step", step, 0);
        chk("rst_dir_out", dir_out, 0);
        chk("rst_drv_en_out", drv_en_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pulse_cnt", pulse_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // counted run, 3 pulses of period 10
        start_run(1'b1, 1'b0, 16'd10, 16'd3);
        wait_cyc(s + 40);
        chk("cnt_rises", rise_q.size(), 3);
        rise_at("cnt_rise0", 0, s + 1);
        rise_at("cnt_rise1", 1, s + 11);
        rise_at("cnt_rise2", 2, s + 21);
        chk("cnt_hi_n", hi_q.size(), 3);
        chk("cnt_hi0", (hi_q.size() > 0) ? hi_q[0] : -1, 4);
        chk("cnt_hi2", (hi_q.size() > 2) ? hi_q[2] : -1, 4);
        chk("cnt_done_len", done_cnt, 1);
        chk("cnt_done_cyc", done_cyc, s + 31);
        chk("cnt_done_pcnt", done_pcnt, 3);
        chk("cnt_pulse_cnt", pulse_cnt, 3);
        chk("cnt_hold_busy", busy, 0);
        chk("cnt_drv_en_out", drv_en_out, 1);
        repeat (10) @(negedge clk);
        chk("cnt_no_restart", rise_q.size(), 3);
        drv_en = 1'b0;
        @(negedge clk);
        chk("cnt_drv_en_out_low", drv_en_out, 0);
        drv_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("cnt_restart", rise_q.size(), 4);
        stop_and_idle();

        // direction change during HIGH in free run, period 12
        start_run(1'b0, 1'b0, 16'd12, 16'd0);
        wait_cyc(s + 3);
        dir = 1'b1;
        wait_cyc(s + 45);
        rise_at("dir_rise0", 0, s + 1);
        chk("dir_hi0", (hi_q.size() > 0) ? hi_q[0] : -1, 4);
        chk("dir_flip_cyc", flip_cyc, s + 13);
        rise_at("dir_rise1", 1, s + 21);
        rise_at("dir_rise2", 2, s + 33);
        chk("dir_out_new", dir_out, 1);
        stop_and_idle();

        // stop two cycles into HIGH
        start_run(1'b0, 1'b1, 16'd10, 16'd0);
        wait_cyc(s + 3);
        drv_en = 1'b0;
        wait_cyc(s + 10);
        chk("stop_busy_last_low", busy, 1);
        chk("stop_step_last_low", step, 0);
        wait_cyc(s + 11);
        chk("stop_busy_after", busy, 0);
        wait_cyc(s + 25);
        chk("stop_rises", rise_q.size(), 1);
        chk("stop_hi0", (hi_q.size() > 0) ? hi_q[0] : -1, 4);

        // clamp: period 3 behaves as 8
        start_run(1'b0, 1'b1, 16'd3, 16'd0);
        wait_cyc(s + 30);
        rise_at("clamp_rise0", 0, s + 1);
        rise_at("clamp_rise1", 1, s + 9);
        rise_at("clamp_rise2", 2, s + 17);
        stop_and_idle();

        // no start for period 0 or a counted run of 0 pulses
        start_run(1'b0, 1'b1, 16'd0, 16'd0);
        repeat (6) @(negedge clk);
        chk("zero_period_busy", busy, 0);
        chk("zero_period_rises", rise_q.size(), 0);
        counter_en = 1'b1;
        period     = 16'd10;
        repeat (6) @(negedge clk);
        chk("zero_count_busy", busy, 0);
        chk("zero_count_rises", rise_q.size(), 0);
        drv_en = 1'b0;
        repeat (2) @(negedge clk);

        // period change mid-LOW takes effect from the next pulse
        start_run(1'b0, 1'b1, 16'd10, 16'd0);
        wait_cyc(s + 7);
        period = 16'd20;
        wait_cyc(s + 60);
        rise_at("upd_rise1", 1, s + 11);
        rise_at("upd_rise2", 2, s + 31);
        rise_at("upd_rise3", 3, s + 51);
        stop_and_idle();

        // reset during HIGH with pulse_cnt = 5
        start_run(1'b0, 1'b1, 16'd8, 16'd0);
        for (int i = 0; i < 200; i++) begin
            if (pulse_cnt == 16'd5 && step == 1'b1) break;
            @(negedge clk);
        end
        chk("rst_pre_cnt", pulse_cnt, 5);
        chk("rst_pre_dir_out", dir_out, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_step", step, 0);
        chk("rst_mid_pulse_cnt", pulse_cnt, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_dir_out", dir_out, 0);
        chk("rst_mid_drv_en_out", drv_en_out, 0);
        rst    = 1'b0;
        drv_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
